// File: rtl/led_pwm_pkg.sv
// Shared types for the LED breathing PWM controller.
//   led_mode_t : output mode requested over the handshake and reported back
//   hs_state_t : mode handshake FSM state
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BREATHE = 2'd1,
    MODE_SYNC    = 2'd2,
    MODE_ON      = 2'd3
  } led_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hs_state_t;

endpackage

// File: rtl/led_breathe_pwm_if.sv
// Control interface of the LED breathing PWM controller.
//   step       : phase increment, sampled at PWM period ends
//   mode_in    : requested mode, qualified by mode_valid
//   mode_valid : request strobe
//   mode_ready : controller can accept a request
//   mode       : currently active mode
interface led_breathe_pwm_if
  import led_pwm_pkg::*;
#(
  parameter int unsigned STEP_W = 16
);
  logic [STEP_W-1:0] step;
  led_mode_t         mode_in;
  logic              mode_valid;
  logic              mode_ready;
  led_mode_t         mode;

  modport master (output step, mode_in, mode_valid, input mode_ready, mode);
  modport slave  (input step, mode_in, mode_valid, output mode_ready, mode);
endinterface

// File: rtl/led_tri_duty.sv
// Folds a phase into a triangle wave and returns the top PWM_BITS of the
// doubled fold as a duty value. Purely combinational.
//   phase  : channel phase
//   duty_c : candidate duty for the next PWM period
module led_tri_duty #(
  parameter int unsigned PHASE_BITS = 32,
  parameter int unsigned PWM_BITS   = 16
) (
  input  logic [PHASE_BITS-1:0] phase,
  output logic [PWM_BITS-1:0]   duty_c
);

  logic [PHASE_BITS-1:0] fold_c;
  logic [PHASE_BITS-1:0] dbl_c;
  logic                  unused_c;

  // Upper half of the phase circle mirrors back down.
  assign fold_c = phase[PHASE_BITS-1] ? ~phase : phase;
  // Fold MSB is always 0, so doubling restores full scale.
  assign dbl_c  = fold_c << 1;
  assign duty_c = dbl_c[PHASE_BITS-1 -: PWM_BITS];

  // Fraction bits below the duty resolution are intentionally dropped.
  assign unused_c = ^dbl_c[PHASE_BITS-PWM_BITS-1:0];

endmodule

// File: rtl/led_breathe_pwm.sv
// Multi-channel breathing LED PWM controller.
//   clk, rst : clock, asynchronous active-high reset
//   ctl      : step input and mode valid/ready handshake (slave side)
//   led      : registered active-high PWM outputs, one per channel
// Mode changes and duty updates only take effect at PWM period ends, so the
// outputs never glitch mid-period.
module led_breathe_pwm
  import led_pwm_pkg::*;
#(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned PWM_BITS   = 16,
  parameter int unsigned PHASE_BITS = 32,
  parameter int unsigned STEP_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  led_breathe_pwm_if.slave    ctl,
  output logic [CHANNELS-1:0] led
);

  // Channel phase spacing: 2^PHASE_BITS / CHANNELS.
  localparam logic [PHASE_BITS:0]   PH_SPAN = {1'b1, {PHASE_BITS{1'b0}}};
  localparam logic [PHASE_BITS-1:0] PH_OFS  =
    PHASE_BITS'(PH_SPAN / (PHASE_BITS+1)'(CHANNELS));

  logic [PWM_BITS-1:0]                cnt_q, cnt_d;
  logic [PHASE_BITS-1:0]              acc_q, acc_d;
  led_mode_t                          mode_q, mode_d;
  led_mode_t                          pending_q, pending_d;
  hs_state_t                          state_q, state_d;
  logic                               ready_q, ready_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  duty_q, duty_d;
  logic [CHANNELS-1:0]                led_q, led_d;

  logic [STEP_W-1:0]                  step_c;
  logic                               pend_c;
  logic [CHANNELS-1:0][PHASE_BITS-1:0] ph_c;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  cand_c;

  assign step_c = ctl.step;
  assign pend_c = &cnt_q;

  // Per-channel phase (uses the post-update mode) and triangle duty.
  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    localparam logic [PHASE_BITS-1:0] OFS = PHASE_BITS'(PH_OFS * PHASE_BITS'(g));

    assign ph_c[g] = (mode_d == MODE_SYNC) ? acc_q : acc_q + OFS;

    led_tri_duty #(
      .PHASE_BITS (PHASE_BITS),
      .PWM_BITS   (PWM_BITS)
    ) u_tri (
      .phase  (ph_c[g]),
      .duty_c (cand_c[g])
    );
  end

  // Period counter, phase accumulator and mode handshake.
  always_comb begin
    cnt_d     = cnt_q + PWM_BITS'(1);
    acc_d     = acc_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    state_d   = state_q;
    ready_d   = ready_q;

    if (pend_c) begin
      acc_d = acc_q + PHASE_BITS'(step_c);
    end

    case (state_q)
      ST_IDLE: begin
        if (ctl.mode_valid && ready_q) begin
          if (pend_c) begin
            // Period ends this cycle: apply directly, no wait needed.
            mode_d = ctl.mode_in;
          end else begin
            pending_d = ctl.mode_in;
            state_d   = ST_WAIT;
            ready_d   = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (pend_c) begin
          mode_d  = pending_q;
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Duty reload at period end; LED compare against the held duty.
  always_comb begin
    duty_d = duty_q;
    led_d  = '0;

    if (pend_c) begin
      duty_d = cand_c;
    end

    case (mode_q)
      MODE_OFF: led_d = '0;
      MODE_ON:  led_d = '1;
      default: begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
          led_d[i] = (cnt_q < duty_q[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      mode_q    <= MODE_OFF;
      pending_q <= MODE_OFF;
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      duty_q    <= '0;
      led_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      ready_q   <= ready_d;
      duty_q    <= duty_d;
      led_q     <= led_d;
    end
  end

  assign ctl.mode_ready = ready_q;
  assign ctl.mode       = mode_q;
  assign led            = led_q;

endmodule
